// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if
//   Bundles the FIFO push/pop handshake, the status flags and the single-port
//   RAM drive of ram_fifo_ctrl.
//   slave  : seen by the controller (push/pop requests and ram_q in,
//            everything else out).
//   master : seen by the requester/RAM side (the mirror image).
//   Parameters: DW data width (matches the RAM word), AW address width.
interface ram_fifo_ctrl_if #(
  parameter int DW = 4,
  parameter int AW = 5
);
  logic          push;
  logic [DW-1:0] push_data;
  logic          push_ready;
  logic          pop;
  logic          pop_ready;
  logic          pop_valid;
  logic [DW-1:0] pop_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_q;

  modport slave (
    input  push, push_data, pop, ram_q,
    output push_ready, pop_ready, pop_valid, pop_data,
           full, empty, count, ram_we, ram_addr, ram_din
  );

  modport master (
    output push, push_data, pop, ram_q,
    input  push_ready, pop_ready, pop_valid, pop_data,
           full, empty, count, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
//   FIFO controller in front of a single-port 2**AW x DW RAM with a one-cycle
//   registered read. One RAM access per cycle: push and pop are arbitrated.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : ram_fifo_ctrl_if.slave (push/pop handshake, full/empty/count,
//             pop_valid/pop_data, RAM we/addr/din drive and RAM q return)
//   Build option:
//     RAM_FIFO_FAIR_EN : when defined, contended cycles alternate between pop
//                        and push using a toggling priority flag; otherwise
//                        pop always wins.
module ram_fifo_ctrl #(
  parameter int DW = 4,
  parameter int AW = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_fifo_ctrl_if.slave      bus
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          pop_valid_q, pop_valid_d;
`ifdef RAM_FIFO_FAIR_EN
  logic          prio_q, prio_d;
`endif

  logic          full_s, empty_s;
  logic          can_push_s, can_pop_s;
  logic          push_grant_s, pop_grant_s;
  logic          push_ready_s, pop_ready_s;

  assign full_s  = (count_q == DEPTH);
  assign empty_s = (count_q == {(AW+1){1'b0}});

  // Gating with rst_n keeps ram_we and both readies low while reset is held.
  assign can_push_s = rst_n & bus.push & ~full_s;
  assign can_pop_s  = rst_n & bus.pop  & ~empty_s;

  // Arbitration; each ready is what the grant would be if its own request
  // were high, so neither ready depends on its own request.
  always_comb begin
`ifdef RAM_FIFO_FAIR_EN
    pop_grant_s  = can_pop_s  & ~(can_push_s & prio_q);
    push_grant_s = can_push_s & ~(can_pop_s & ~prio_q);
    push_ready_s = rst_n & ~full_s  & ~(can_pop_s & ~prio_q);
    pop_ready_s  = rst_n & ~empty_s & ~(can_push_s & prio_q);
`else
    pop_grant_s  = can_pop_s;
    push_grant_s = can_push_s & ~can_pop_s;
    push_ready_s = rst_n & ~full_s & ~can_pop_s;
    pop_ready_s  = rst_n & ~empty_s;
`endif
  end

  // RAM drive: write on a push grant, otherwise present the read pointer.
  always_comb begin
    bus.ram_we   = 1'b0;
    bus.ram_addr = rd_ptr_q;
    bus.ram_din  = {DW{1'b0}};
    if (push_grant_s) begin
      bus.ram_we   = 1'b1;
      bus.ram_addr = wr_ptr_q;
      bus.ram_din  = bus.push_data;
    end else begin
      bus.ram_we   = 1'b0;
      bus.ram_addr = rd_ptr_q;
      bus.ram_din  = {DW{1'b0}};
    end
  end

  // Next-state: pointers wrap naturally at 2**AW; at most one grant per cycle.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pop_valid_d = pop_grant_s;
    if (push_grant_s) begin
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_grant_s) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_grant_s, pop_grant_s})
      2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

`ifdef RAM_FIFO_FAIR_EN
  // Fairness flag flips after every contended cycle.
  assign prio_d = prio_q ^ (can_push_s & can_pop_s);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {(AW+1){1'b0}};
      pop_valid_q <= 1'b0;
`ifdef RAM_FIFO_FAIR_EN
      prio_q      <= 1'b0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pop_valid_q <= pop_valid_d;
`ifdef RAM_FIFO_FAIR_EN
      prio_q      <= prio_d;
`endif
    end
  end

  assign bus.push_ready = push_ready_s;
  assign bus.pop_ready  = pop_ready_s;
  assign bus.pop_valid  = pop_valid_q;
  assign bus.pop_data   = pop_valid_q ? bus.ram_q : {DW{1'b0}};
  assign bus.full       = full_s;
  assign bus.empty      = empty_s;
  assign bus.count      = count_q;
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: a behavioural 32x4 RAM with registered q, a
// spec-level FIFO model that predicts grants and pushes expected pop data
// into a scoreboard, and a monitor that checks pop_data on every pop_valid.
module tb_ram_fifo_ctrl;
  localparam int DW = 4;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  ram_fifo_ctrl_if #(.DW(DW), .AW(AW)) bus ();
  ram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // RAM stage: write at the edge, q registered one cycle after the address.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_we === 1'b1) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_q <= mem[bus.ram_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] m_data [$];
  int m_wr = 0;
  int m_rd = 0;
  bit m_prio = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data.delete();
    exp_q.delete();
    m_wr = 0;
    m_rd = 0;
    m_prio = 1'b0;
  endtask

  // One cycle of stimulus; inputs change 1 time unit after the rising edge.
  task automatic step(input bit p, input logic [DW-1:0] d, input bit q);
    bit cpush, cpop, gpush, gpop, pr, qr;
    bus.push = p; bus.push_data = d; bus.pop = q;
    cpush = p && (m_data.size() < DEPTH);
    cpop  = q && (m_data.size() > 0);
`ifdef RAM_FIFO_FAIR_EN
    gpop  = cpop && !(cpush && m_prio);
    gpush = cpush && !(cpop && !m_prio);
    pr    = (m_data.size() < DEPTH) && !(cpop && !m_prio);
    qr    = (m_data.size() > 0) && !(cpush && m_prio);
`else
    gpop  = cpop;
    gpush = cpush && !cpop;
    pr    = (m_data.size() < DEPTH) && !cpop;
    qr    = (m_data.size() > 0);
`endif
    @(negedge clk);
    check("push_ready", bus.push_ready, pr);
    check("pop_ready", bus.pop_ready, qr);
    check("ram_we", bus.ram_we, gpush);
    check("ram_addr", bus.ram_addr, gpush ? m_wr : m_rd);
    check("ram_din", bus.ram_din, gpush ? d : 0);
    if (gpush) begin
      m_data.push_back(d);
      m_wr = (m_wr + 1) % DEPTH;
    end
    if (gpop) begin
      exp_q.push_back(m_data.pop_front());
      m_rd = (m_rd + 1) % DEPTH;
    end
    if (cpush && cpop) m_prio = !m_prio;
    @(posedge clk);
    #1;
    check("count", bus.count, m_data.size());
    check("full", bus.full, m_data.size() == DEPTH);
    check("empty", bus.empty, m_data.size() == 0);
    check("pop_valid", bus.pop_valid, gpop);
  endtask

  // Monitor: compare every presented pop word against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.pop_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pop_unexpected: got data %0d expected no pop_valid", bus.pop_data);
        end else begin
          check("pop_data", bus.pop_data, exp_q.pop_front());
        end
      end else begin
        check("pop_data_idle", bus.pop_data, 0);
      end
    end
  end

  initial begin
    bus.push = 1'b0; bus.push_data = '0; bus.pop = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_pop_valid", bus.pop_valid, 0);
    check("rst_pop_data", bus.pop_data, 0);
    check("rst_push_ready", bus.push_ready, 0);
    check("rst_pop_ready", bus.pop_ready, 0);
    check("rst_ram_we", bus.ram_we, 0);
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_ram_din", bus.ram_din, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Five pushes then five back-to-back pops.
    for (int i = 1; i <= 5; i++) step(1'b1, 4'(i), 1'b0);
    check("five_count", bus.count, 5);
    check("five_empty", bus.empty, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b0);
    check("drain_count", bus.count, 0);
    check("drain_empty", bus.empty, 1);

    // Fill to 32 (addresses 5..31 then wrap to 0..4), overfill, drain.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 4'(i % 16), 1'b0);
    check("fill_full", bus.full, 1);
    check("fill_count", bus.count, 32);
    step(1'b1, 4'd7, 1'b0);
    check("overfill_count", bus.count, 32);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b0);
    check("refill_empty", bus.empty, 1);

    // Contention with count=3.
    for (int i = 9; i <= 11; i++) step(1'b1, 4'(i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'd12, 1'b1);
`ifdef RAM_FIFO_FAIR_EN
    check("contend_count", bus.count, 3);
`else
    check("contend_count", bus.count, 1);
`endif
    while (m_data.size() > 0) step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b0);

    // Pop while empty.
    step(1'b0, 4'd0, 1'b1);
    check("empty_pop_count", bus.count, 0);
    check("empty_pop_data", bus.pop_data, 0);
    step(1'b0, 4'd0, 1'b0);

    // Asynchronous reset mid-burst with a pop in flight.
    for (int i = 0; i < 8; i++) step(1'b1, 4'(i + 3), 1'b0);
    step(1'b0, 4'd0, 1'b1);
    check("pre_reset_count", bus.count, 7);
    bus.push = 1'b1; bus.push_data = 4'd15;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_count", bus.count, 0);
    check("arst_empty", bus.empty, 1);
    check("arst_pop_valid", bus.pop_valid, 0);
    check("arst_ram_we", bus.ram_we, 0);
    check("arst_push_ready", bus.push_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.push = 1'b0;
    step(1'b1, 4'd6, 1'b0);
    step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
